// File: rtl/glyph_scanner.sv
// Glyph scanner: streams an N x N glyph as a raster of
// SCALE-replicated pixels over a valid/ready handshake.
module glyph_scanner #(
  parameter int N     = 5,
  parameter int SCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_start,
  input  logic [2:0]   in_glyph,
  input  logic         in_ready,
  output logic         out_valid,
  output logic         out_pix,
  output logic [N-1:0] out_row_code,
  output logic         out_eol,
  output logic         out_last,
  output logic         out_busy
);

  localparam int CW = $clog2(N);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [CW-1:0] MID   = CW'(N / 2);
  localparam logic [SW-1:0] SLAST = SW'(SCALE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_glyph;
  logic [CW-1:0] r_row;
  logic [SW-1:0] r_vrep;
  logic [CW-1:0] r_col;
  logic [SW-1:0] r_hrep;

  logic          w_run;
  logic          w_fire;
  logic          w_accept;
  logic          w_hwrap;
  logic          w_cwrap;
  logic          w_vwrap;
  logic          w_rwrap;
  logic          w_eol;
  logic          w_last;
  logic          w_pix;
  logic [N-1:0]  w_row_code;

  function automatic logic f_pix(
    input logic [2:0]    g,
    input logic [CW-1:0] r,
    input logic [CW-1:0] c
  );
    logic diag;
    logic anti;
    logic hbar;
    logic vbar;
    diag = (c == r);
    anti = (c == LAST - r);
    hbar = (r == MID);
    vbar = (c == MID);
    case (g)
      3'd1:    f_pix = diag;
      3'd2:    f_pix = anti;
      3'd3:    f_pix = hbar | vbar;
      3'd4:    f_pix = hbar;
      3'd5:    f_pix = diag | anti;
      3'd6:    f_pix = 1'b1;
      default: f_pix = 1'b0;
    endcase
  endfunction

  assign w_run    = (r_state == RUN);
  assign w_fire   = w_run && in_ready;
  assign w_accept = (r_state == IDLE) && in_start;
  assign w_hwrap  = (r_hrep == SLAST);
  assign w_cwrap  = (r_col == LAST);
  assign w_vwrap  = (r_vrep == SLAST);
  assign w_rwrap  = (r_row == LAST);
  assign w_eol    = w_cwrap && w_hwrap;
  assign w_last   = w_eol && w_vwrap && w_rwrap;
  assign w_pix    = f_pix(r_glyph, r_row, r_col);

  always_comb begin
    w_row_code = '0;
    for (int i = 0; i < N; i++) begin
      w_row_code[N-1-i] = f_pix(r_glyph, r_row, CW'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_start) w_next = RUN;
      RUN:     if (w_fire && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_glyph <= '0;
      r_row   <= '0;
      r_vrep  <= '0;
      r_col   <= '0;
      r_hrep  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_glyph <= in_glyph;
        r_row   <= '0;
        r_vrep  <= '0;
        r_col   <= '0;
        r_hrep  <= '0;
      end else if (w_fire) begin
        // Odometer: each wrapping counter carries outward.
        r_hrep <= w_hwrap ? '0 : r_hrep + 1'b1;
        if (w_hwrap) begin
          r_col <= w_cwrap ? '0 : r_col + 1'b1;
          if (w_cwrap) begin
            r_vrep <= w_vwrap ? '0 : r_vrep + 1'b1;
            if (w_vwrap) begin
              r_row <= w_rwrap ? '0 : r_row + 1'b1;
            end
          end
        end
      end
    end
  end

  assign out_valid    = w_run;
  assign out_busy     = w_run;
  assign out_pix      = w_run & w_pix;
  assign out_row_code = w_run ? w_row_code : '0;
  assign out_eol      = w_run & w_eol;
  assign out_last     = w_run & w_last;

endmodule

// File: tb/tb_glyph_scanner.sv
// Scoreboard bench for glyph_scanner: two instances
// (SCALE=1 and SCALE=2), hand-written row tables.
module tb_glyph_scanner;

  typedef struct packed {
    logic       pix;
    logic [4:0] row;
    logic       eol;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s1_start, s2_start;
  logic [2:0] s1_glyph, s2_glyph;
  logic       s1_ready, s2_ready;
  logic       o1_valid, o1_pix, o1_eol, o1_last, o1_busy;
  logic       o2_valid, o2_pix, o2_eol, o2_last, o2_busy;
  logic [4:0] o1_row, o2_row;

  exp_t q1[$];
  exp_t q2[$];
  int   vecs = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  glyph_scanner #(.N(5), .SCALE(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_start(s1_start), .in_glyph(s1_glyph),
    .in_ready(s1_ready), .out_valid(o1_valid),
    .out_pix(o1_pix), .out_row_code(o1_row),
    .out_eol(o1_eol), .out_last(o1_last),
    .out_busy(o1_busy)
  );

  glyph_scanner #(.N(5), .SCALE(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_start(s2_start), .in_glyph(s2_glyph),
    .in_ready(s2_ready), .out_valid(o2_valid),
    .out_pix(o2_pix), .out_row_code(o2_row),
    .out_eol(o2_eol), .out_last(o2_last),
    .out_busy(o2_busy)
  );

  // Hand-drawn 5x5 glyph rows, MSB = leftmost column.
  function automatic logic [4:0] rowpat(input int g, input int r);
    logic [4:0] t [5];
    case (g)
      1: t = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
      2: t = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      3: t = '{5'b00100, 5'b00100, 5'b11111, 5'b00100, 5'b00100};
      4: t = '{5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000};
      5: t = '{5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001};
      6: t = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
      default: t = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    endcase
    return t[r];
  endfunction

  task automatic push_scan(input bit d2, input int g, input int limit);
    int   s;
    int   n;
    exp_t e;
    logic [4:0] rp;
    s = d2 ? 2 : 1;
    n = 0;
    for (int r = 0; r < 5; r++)
      for (int v = 0; v < s; v++)
        for (int c = 0; c < 5; c++)
          for (int h = 0; h < s; h++) begin
            rp     = rowpat(g, r);
            e.pix  = rp[4-c];
            e.row  = rp;
            e.eol  = (c == 4) && (h == s - 1);
            e.last = e.eol && (r == 4) && (v == s - 1);
            if (n < limit) begin
              if (d2) q2.push_back(e);
              else q1.push_back(e);
            end
            n++;
          end
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitors: pop and compare on every completed transfer.
  logic [8:0] p1_snap, p2_snap;
  bit         p1_stall, p2_stall;

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    got = '{o1_pix, o1_row, o1_eol, o1_last};
    if (!reset && p1_stall) begin
      vecs++;
      if ({o1_valid, got} !== p1_snap) begin
        fails++;
        $display("FAIL d1_stall: got %h expected %h",
                 {o1_valid, got}, p1_snap);
      end
    end
    p1_stall = !reset && o1_valid && !s1_ready;
    p1_snap  = {o1_valid, got};
    if (!reset && o1_valid && s1_ready) begin
      vecs++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL d1_extra: got %h expected none", got);
      end else begin
        e = q1.pop_front();
        if (got !== e || o1_busy !== 1'b1) begin
          fails++;
          $display("FAIL d1_pix: got %h busy %b expected %h busy 1",
                   got, o1_busy, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    got = '{o2_pix, o2_row, o2_eol, o2_last};
    if (!reset && p2_stall) begin
      vecs++;
      if ({o2_valid, got} !== p2_snap) begin
        fails++;
        $display("FAIL d2_stall: got %h expected %h",
                 {o2_valid, got}, p2_snap);
      end
    end
    p2_stall = !reset && o2_valid && !s2_ready;
    p2_snap  = {o2_valid, got};
    if (!reset && o2_valid && s2_ready) begin
      vecs++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL d2_extra: got %h expected none", got);
      end else begin
        e = q2.pop_front();
        if (got !== e || o2_busy !== 1'b1) begin
          fails++;
          $display("FAIL d2_pix: got %h busy %b expected %h busy 1",
                   got, o2_busy, e);
        end
      end
    end
  end

  task automatic do_start(input bit d2, input int g);
    @(posedge clk);
    #1;
    if (d2) begin
      s2_start = 1'b1;
      s2_glyph = 3'(g);
    end else begin
      s1_start = 1'b1;
      s1_glyph = 3'(g);
    end
    @(posedge clk);
    #1;
    s1_start = 1'b0;
    s2_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((o1_valid || o2_valid || q1.size() != 0 ||
            q2.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(nm, {q1.size() == 0, q2.size() == 0, n < 4000},
          {1'b1, 1'b1, 1'b1});
  endtask

  function automatic logic [31:0] outs1();
    return {o1_valid, o1_busy, o1_pix, o1_row, o1_eol, o1_last};
  endfunction

  function automatic logic [31:0] outs2();
    return {o2_valid, o2_busy, o2_pix, o2_row, o2_eol, o2_last};
  endfunction

  initial begin
    int n;
    reset    = 1'b1;
    s1_start = 1'b0;
    s2_start = 1'b0;
    s1_glyph = 3'd0;
    s2_glyph = 3'd0;
    s1_ready = 1'b1;
    s2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 s1_start = 1'b1;
    @(negedge clk);
    check("reset_d1", outs1(), 0);
    check("reset_d2", outs2(), 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    s1_start = 1'b0;

    // Backslash, always ready.
    push_scan(0, 1, 1000);
    do_start(0, 1);
    wait_done("done_g1");

    // Plus at SCALE=2.
    push_scan(1, 3, 1000);
    do_start(1, 3);
    wait_done("done_g3_x2");

    // Times with random back-pressure.
    push_scan(0, 5, 1000);
    s1_ready = 1'($urandom_range(0, 1));
    do_start(0, 5);
    n = 0;
    while (o1_busy && n < 2000) begin
      @(posedge clk);
      #1 s1_ready = 1'($urandom_range(0, 1));
      n++;
    end
    s1_ready = 1'b1;
    check("g5_bound", n < 2000, 1);
    wait_done("done_g5_stall");

    // Same with SCALE=2.
    push_scan(1, 5, 1000);
    do_start(1, 5);
    n = 0;
    while (o2_busy && n < 2000) begin
      @(posedge clk);
      #1 s2_ready = 1'($urandom_range(0, 1));
      n++;
    end
    s2_ready = 1'b1;
    wait_done("done_g5_x2_stall");

    // Start request during a scan is ignored.
    push_scan(0, 2, 1000);
    do_start(0, 2);
    repeat (6) @(posedge clk);
    #1;
    s1_start = 1'b1;
    s1_glyph = 3'd6;
    @(posedge clk);
    #1;
    s1_start = 1'b0;
    s1_glyph = 3'd0;
    wait_done("done_g2_ignore");

    // Start held during the final transfer is ignored.
    push_scan(0, 4, 1000);
    do_start(0, 4);
    repeat (24) @(posedge clk);
    #1;
    s1_start = 1'b1;
    s1_glyph = 3'd6;
    @(negedge clk);
    check("last_shown", {o1_last, o1_eol}, 2'b11);
    @(posedge clk);
    #1 s1_start = 1'b0;
    @(negedge clk);
    check("idle_after_last", outs1(), 0);
    wait_done("done_g4");

    // Reset at pixel 12 aborts the scan.
    push_scan(0, 6, 11);
    do_start(0, 6);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_idle", outs1(), 0);
    check("abort_q", q1.size(), 0);
    push_scan(0, 1, 1000);
    do_start(0, 1);
    @(negedge clk);
    check("restart_row0", o1_row, 5'b10000);
    wait_done("done_restart");

    // Blank glyphs.
    push_scan(0, 7, 1000);
    do_start(0, 7);
    wait_done("done_g7");
    push_scan(0, 0, 1000);
    do_start(0, 0);
    wait_done("done_g0");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule

// File: doc/glyph_scanner.md
GLYPH_SCANNER -- requirements
Module: glyph_scanner

Interface
REQ-001 SHALL have parameter N, default 5, meaning glyph cell side in pixels; legal range 3..16.
REQ-002 SHALL have parameter SCALE, default 1, meaning horizontal and vertical pixel replication factor; legal range 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_start  input  1  request to scan one glyph; sampled only in IDLE.
REQ-006 SHALL have port in_glyph  input  3  glyph select; latched with an accepted in_start.
REQ-007 SHALL have port in_ready  input  1  downstream accepts the current pixel when high with out_valid.
REQ-008 SHALL have port out_valid  output  1  out_pix, out_row_code, out_eol and out_last are valid.
REQ-009 SHALL have port out_pix  output  1  current pixel: 1 = ink, 0 = background.
REQ-010 SHALL have port out_row_code  output  N  unscaled pattern of the current glyph row; MSB = leftmost column.
REQ-011 SHALL have port out_eol  output  1  current pixel is the last pixel of a scaled output line.
REQ-012 SHALL have port out_last  output  1  current pixel is the final pixel of the glyph.
REQ-013 SHALL have port out_busy  output  1  high whenever the state is RUN.

Function
REQ-014 SHALL define pixel(r,c), with r, c in 0..N-1 and M = N/2 (integer division), by in_glyph: 0 blank (all 0); 1 backslash (c==r); 2 slash (c==N-1-r); 3 plus (r==M or c==M); 4 minus (r==M); 5 times (c==r or c==N-1-r); 6 block (all 1); 7 blank.
REQ-015 SHALL set out_row_code bit (N-1-c) to pixel(r,c) for the current row r, so that glyph 1 row 0 with N=5 is 10000.
REQ-016 SHALL implement the two-state FSM IDLE and RUN.
REQ-017 SHALL move IDLE->RUN on the edge where in_start=1, latch in_glyph, and clear all counters.
REQ-018 SHALL ignore in_start and in_glyph changes while in RUN; the latched glyph is used for the whole scan.
REQ-019 SHALL hold out_valid=1 throughout RUN, with the first pixel valid the cycle after start acceptance (latency 1).
REQ-020 SHALL complete a transfer when out_valid=1 and in_ready=1, and only then advance the counters.
REQ-021 SHALL keep all outputs and counters stable while in_ready=0.
REQ-022 SHALL order the scan as: row r (outermost), vertical repeat v, column c, horizontal repeat h (innermost); each counter wraps to 0 and carries into the next outer counter.
REQ-023 SHALL emit exactly (N*SCALE)^2 pixels per glyph.
REQ-024 SHALL assert out_eol when c==N-1 and h==SCALE-1.
REQ-025 SHALL assert out_last when r==N-1, v==SCALE-1, c==N-1 and h==SCALE-1.
REQ-026 SHALL return RUN->IDLE on the transfer of the out_last pixel; out_valid is 0 the following cycle.
REQ-027 SHALL ignore an in_start that is high in the same cycle as the final transfer; a new scan starts at earliest on the first IDLE cycle.
REQ-028 SHALL drive out_pix, out_row_code, out_eol and out_last to 0 whenever out_valid=0.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, enter IDLE, clear all counters and the latched glyph, and drive out_valid, out_busy, out_pix, out_eol, out_last=0 and out_row_code=0.
REQ-030 SHALL give reset priority over in_start and over any transfer, including mid-scan; the aborted scan produces no further pixels.

Verification
REQ-031 SHALL cover: N=5, SCALE=1, glyph 1, in_ready=1 -> 25 pixels; rows 10000, 01000, 00100, 00010, 00001; out_eol on pixels 5, 10, 15, 20, 25; out_last on pixel 25.
REQ-032 SHALL cover: N=5, SCALE=2, glyph 3 -> 100 pixels; lines 0-3 show ink at positions 4-5 only; lines 4-5 are all ink; out_row_code=11111 on row 2.
REQ-033 SHALL cover: glyph 5 with in_ready toggled pseudo-randomly -> pixel sequence identical to the in_ready=1 run; outputs stable during stalls.
REQ-034 SHALL cover: in_start pulsed with glyph 6 during a glyph 2 scan -> glyph 2 completes unchanged; the second request is not executed.
REQ-035 SHALL cover: reset asserted at pixel 12 -> out_valid=0 on the next cycle; a new start yields a full 25-pixel scan from row 0.
REQ-036 SHALL cover: glyph 7 and glyph 0 -> 25 pixels all 0, out_row_code=00000, out_last on pixel 25.
